// File: rtl/shift32_seq_pkg.sv
// Shared definitions for the shift-register command sequencer.
// Op codes match the cmd_op encoding. Mode constants are the {S1,S0} pin values.
// State encoding is used by the sequencer FSM only.
package shift32_seq_pkg;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_SHL   = 3'b001,
    OP_SHR   = 3'b010,
    OP_SAR   = 3'b011,
    OP_ROL   = 3'b100,
    OP_ROR   = 3'b101,
    OP_CLEAR = 3'b110,
    OP_RSVD  = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CLR   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift32_sequencer.sv
// Sequencer that turns load/shift/rotate/clear commands into per-cycle mode and serial pins of a universal shift register.
// Latency: LOAD/CLEAR done 2 cycles after accept, N-bit shift done N+1 after, amt=0 or reserved op done 1 after.
// Backpressure: cmd_ready is high only when idle; commands offered while busy wait. Optional SHIFT32_SEQ_STATS_EN adds shift_cycles.
module shift32_sequencer
  import shift32_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] q_in,
  output logic             S1,
  output logic             S0,
  output logic             SR,
  output logic             SL,
  output logic [WIDTH-1:0] PData,
  output logic             clear,
  output logic             busy,
  output logic             done,
  output logic             bad_op
`ifdef SHIFT32_SEQ_STATS_EN
  ,
  output logic [31:0]      shift_cycles
`endif
);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [AMT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [1:0]         mode;

  // Only the end bits of Q feed back (fill/rotate); the rest is deliberately ignored.
  logic q_in_unused;
  assign q_in_unused = ^q_in[WIDTH-2:1];

  // State, latched command and remaining step count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Next-state: accept in IDLE, count shift steps down to 1, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d   = op_e'(cmd_op);
          cnt_d  = cmd_amt;
          data_d = cmd_data;
          case (op_e'(cmd_op))
            OP_LOAD:  state_d = ST_LOAD;
            OP_CLEAR: state_d = ST_CLR;
            OP_RSVD:  state_d = ST_DONE;
            default:  state_d = (cmd_amt == '0) ? ST_DONE : ST_SHIFT;
          endcase
        end
      end
      ST_LOAD:  state_d = ST_DONE;
      ST_CLR:   state_d = ST_DONE;
      ST_SHIFT: begin
        if (cnt_q == AMT_W'(1)) state_d = ST_DONE;
        else                    cnt_d   = cnt_q - AMT_W'(1);
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode: mode/PData/clear from state only; serial pins also look at Q for fill and rotate.
  always_comb begin
    mode      = MODE_HOLD;
    SR        = 1'b0;
    SL        = 1'b0;
    PData     = '0;
    clear     = 1'b0;
    done      = 1'b0;
    bad_op    = 1'b0;
    cmd_ready = 1'b0;
    case (state_q)
      ST_IDLE: cmd_ready = 1'b1;
      ST_LOAD: begin
        mode  = MODE_LOAD;
        PData = data_q;
      end
      ST_CLR:  clear = 1'b1;
      ST_SHIFT: begin
        case (op_q)
          OP_SHL: mode = MODE_SHL;
          OP_SHR: mode = MODE_SHR;
          OP_SAR: begin
            mode = MODE_SHR;
            SR   = q_in[WIDTH-1];
          end
          OP_ROL: begin
            mode = MODE_SHL;
            SL   = q_in[WIDTH-1];
          end
          OP_ROR: begin
            mode = MODE_SHR;
            SR   = q_in[0];
          end
          default: mode = MODE_HOLD;
        endcase
      end
      ST_DONE: begin
        done   = 1'b1;
        bad_op = (op_q == OP_RSVD);
      end
      default: mode = MODE_HOLD;
    endcase
  end

  assign S1   = mode[1];
  assign S0   = mode[0];
  assign busy = ~cmd_ready;

`ifdef SHIFT32_SEQ_STATS_EN
  logic [31:0] shift_cycles_q;

  // Saturating count of cycles spent stepping the shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      shift_cycles_q <= '0;
    else if (state_q == ST_SHIFT && shift_cycles_q != 32'hFFFF_FFFF)
      shift_cycles_q <= shift_cycles_q + 32'd1;
  end

  assign shift_cycles = shift_cycles_q;
`endif

endmodule

// File: tb/tb_shift32_sequencer.sv
// Bench for shift32_sequencer: drives commands into the sequencer, closes the loop through a
// behavioural 32-bit universal shift register, and compares each op's result, latency and
// status against an arithmetic model of the command set.
module tb_shift32_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [4:0]  cmd_amt = 5'd0;
  logic [31:0] cmd_data = 32'd0;
  logic [31:0] q_reg = 32'd0;
  logic        S1, S0, SR, SL, clear, busy, done, bad_op;
  logic [31:0] PData;
`ifdef SHIFT32_SEQ_STATS_EN
  logic [31:0] shift_cycles;
`endif

  int          n_pass = 0;
  int          n_tot  = 0;
  logic [31:0] exp_q  = 32'd0;

  shift32_sequencer #(.WIDTH(32), .AMT_W(5)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data),
    .q_in(q_reg),
    .S1(S1), .S0(S0), .SR(SR), .SL(SL),
    .PData(PData), .clear(clear), .busy(busy), .done(done), .bad_op(bad_op)
`ifdef SHIFT32_SEQ_STATS_EN
    , .shift_cycles(shift_cycles)
`endif
  );

  always #5 clk = ~clk;

  // The controlled universal shift register (plant); it is not reset by rst.
  always @(posedge clk) begin
    if (clear) q_reg <= 32'd0;
    else case ({S1, S0})
      2'b01:   q_reg <= {SR, q_reg[31:1]};
      2'b10:   q_reg <= {q_reg[30:0], SL};
      2'b11:   q_reg <= PData;
      default: q_reg <= q_reg;
    endcase
  end

  // Reference result of one command applied to register value q.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [4:0] amt,
                                        input logic [31:0] d, input logic [31:0] q);
    int n;
    n = int'(amt);
    case (op)
      3'd0: return d;
      3'd1: return q << n;
      3'd2: return q >> n;
      3'd3: return $unsigned($signed(q) >>> n);
      3'd4: return (n == 0) ? q : ((q << n) | (q >> (32 - n)));
      3'd5: return (n == 0) ? q : ((q >> n) | (q << (32 - n)));
      3'd6: return 32'd0;
      default: return q;
    endcase
  endfunction

  // Cycles from the accepting edge until done is visible.
  function automatic int exp_lat(input logic [2:0] op, input logic [4:0] amt);
    if (op == 3'd0 || op == 3'd6) return 2;
    if (op == 3'd7) return 1;
    return (amt == 5'd0) ? 1 : int'(amt) + 1;
  endfunction

  // Cycles in which the register is told to do something (load, clear or a shift step).
  function automatic int exp_act(input logic [2:0] op, input logic [4:0] amt);
    if (op == 3'd0 || op == 3'd6) return 1;
    if (op == 3'd7) return 0;
    return int'(amt);
  endfunction

  // Issue one command from idle and record what happened until done (no checking here).
  task automatic run_op(input logic [2:0] op, input logic [4:0] amt, input logic [31:0] data,
                        output int lat, output int act, output logic [31:0] q_done,
                        output logic bad, output logic pins_ok, output logic [31:0] pd_seen);
    cmd_op = op; cmd_amt = amt; cmd_data = data; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    lat = 1; act = 0; pins_ok = 1'b1; pd_seen = 32'd0;
    while (done !== 1'b1 && lat < 200) begin
      if ({S1, S0} != 2'b00 || clear) act++;
      if ({S1, S0} == 2'b11) pd_seen = PData;
      else if (PData !== 32'd0) pins_ok = 1'b0;
      if (cmd_ready !== 1'b0) pins_ok = 1'b0;
      @(negedge clk); lat++;
    end
    q_done = q_reg; bad = bad_op;
    if ({S1, S0} !== 2'b00 || cmd_ready !== 1'b0 || clear !== 1'b0) pins_ok = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    n_tot++;
    if ({cmd_ready, busy, S1, S0, SR, SL, clear, done, bad_op} !== 9'b1_0000_0000) begin
      $display("FAIL reset_pins got %b want %b", {cmd_ready, busy, S1, S0, SR, SL, clear, done, bad_op}, 9'b1_0000_0000);
    end else n_pass++;
    n_tot++;
    if (PData !== 32'd0) $display("FAIL reset_pdata got %h want 0", PData);
    else n_pass++;
  endtask

  task automatic test_directed;
    logic [2:0]  t_op  [9] = '{3'd0, 3'd1, 3'd0, 3'd3, 3'd0, 3'd5, 3'd2, 3'd7, 3'd6};
    logic [4:0]  t_amt [9] = '{5'd0, 5'd4, 5'd0, 5'd31, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0};
    logic [31:0] t_dat [9] = '{32'h8000_0001, 32'h0, 32'h8000_0000, 32'h0, 32'h0000_0001,
                               32'h0, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0};
    int lat, act; logic [31:0] q, pd; logic bad, ok;
    for (int i = 0; i < 9; i++) begin
      run_op(t_op[i], t_amt[i], t_dat[i], lat, act, q, bad, ok, pd);
      exp_q = model(t_op[i], t_amt[i], t_dat[i], exp_q);
      n_tot++;
      if (lat !== exp_lat(t_op[i], t_amt[i])) $display("FAIL dir%0d_latency got %0d want %0d", i, lat, exp_lat(t_op[i], t_amt[i]));
      else n_pass++;
      n_tot++;
      if (q !== exp_q) $display("FAIL dir%0d_result got %h want %h", i, q, exp_q);
      else n_pass++;
      n_tot++;
      if (bad !== (t_op[i] == 3'd7)) $display("FAIL dir%0d_bad_op got %b want %b", i, bad, t_op[i] == 3'd7);
      else n_pass++;
      n_tot++;
      if (act !== exp_act(t_op[i], t_amt[i]) || ok !== 1'b1) $display("FAIL dir%0d_pins active %0d want %0d pins_ok %b", i, act, exp_act(t_op[i], t_amt[i]), ok);
      else n_pass++;
      if (t_op[i] == 3'd0) begin
        n_tot++;
        if (pd !== t_dat[i]) $display("FAIL dir%0d_pdata got %h want %h", i, pd, t_dat[i]);
        else n_pass++;
      end
    end
    // Spot-check the model itself against known results on the last states.
    n_tot++;
    if (exp_q !== 32'd0 || q_reg !== 32'd0) $display("FAIL dir_clear_final got %h want 0", q_reg);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [2:0] op; logic [4:0] amt; logic [31:0] d, q, pd;
    int lat, act; logic bad, ok;
    for (int i = 0; i < 30; i++) begin
      op  = 3'($urandom_range(0, 7));
      amt = 5'($urandom_range(0, 31));
      d   = $urandom;
      run_op(op, amt, d, lat, act, q, bad, ok, pd);
      exp_q = model(op, amt, d, exp_q);
      n_tot++;
      if (lat !== exp_lat(op, amt) || bad !== (op == 3'd7))
        $display("FAIL rnd%0d_timing op %0d amt %0d latency %0d want %0d bad %b", i, op, amt, lat, exp_lat(op, amt), bad);
      else n_pass++;
      n_tot++;
      if (q !== exp_q) $display("FAIL rnd%0d_result op %0d amt %0d got %h want %h", i, op, amt, q, exp_q);
      else n_pass++;
      n_tot++;
      if (act !== exp_act(op, amt) || ok !== 1'b1) $display("FAIL rnd%0d_pins active %0d want %0d pins_ok %b", i, act, exp_act(op, amt), ok);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    int lat, act; logic [31:0] q, pd, q0, q1; logic bad, ok, held;
    run_op(3'd0, 5'd0, 32'hA5C3_0F81, lat, act, q, bad, ok, pd);
    exp_q = 32'hA5C3_0F81;
    q0 = exp_q;
    cmd_op = 3'd4; cmd_amt = 5'd8; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_op = 3'd1; cmd_amt = 5'd1;
    @(negedge clk);
    lat = 1; held = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (cmd_ready !== 1'b0) held = 1'b0;
      @(negedge clk); lat++;
    end
    q1 = model(3'd4, 5'd8, 32'd0, q0);
    n_tot++;
    if (lat !== 9 || held !== 1'b1) $display("FAIL b2b_first_latency got %0d want 9 held %b", lat, held);
    else n_pass++;
    n_tot++;
    if (q_reg !== q1) $display("FAIL b2b_first_result got %h want %h", q_reg, q1);
    else n_pass++;
    @(negedge clk);
    n_tot++;
    if (cmd_ready !== 1'b1) $display("FAIL b2b_ready_after_done got %b want 1", cmd_ready);
    else n_pass++;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    n_tot++;
    if (busy !== 1'b1 || {S1, S0} !== 2'b10) $display("FAIL b2b_second_start busy %b mode %b want 1 10", busy, {S1, S0});
    else n_pass++;
    @(negedge clk);
    exp_q = model(3'd1, 5'd1, 32'd0, q1);
    n_tot++;
    if (done !== 1'b1 || q_reg !== exp_q) $display("FAIL b2b_second_done done %b got %h want %h", done, q_reg, exp_q);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_rst_mid;
    int lat, act; logic [31:0] q, pd, d; logic bad, ok;
    d = $urandom | 32'h8000_0001;
    run_op(3'd0, 5'd0, d, lat, act, q, bad, ok, pd);
    cmd_op = 3'd2; cmd_amt = 5'd20; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_tot++;
    if ({cmd_ready, busy, S1, S0, SR, SL, clear, done, bad_op} !== 9'b1_0000_0000 || PData !== 32'd0)
      $display("FAIL rst_mid_pins got %b want %b", {cmd_ready, busy, S1, S0, SR, SL, clear, done, bad_op}, 9'b1_0000_0000);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    n_tot++;
    if (q_reg !== (d >> 5)) $display("FAIL rst_mid_partial got %h want %h", q_reg, d >> 5);
    else n_pass++;
    @(negedge clk);
    n_tot++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rst_mid_ready got %b want 1", cmd_ready);
    else n_pass++;
    exp_q = q_reg;
  endtask

`ifdef SHIFT32_SEQ_STATS_EN
  task automatic test_stats;
    int lat, act; logic [31:0] q, pd; logic bad, ok;
    rst = 1'b1; #1;
    n_tot++;
    if (shift_cycles !== 32'd0) $display("FAIL stats_reset got %0d want 0", shift_cycles);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    run_op(3'd1, 5'd4, 32'd0, lat, act, q, bad, ok, pd);
    run_op(3'd2, 5'd3, 32'd0, lat, act, q, bad, ok, pd);
    n_tot++;
    if (shift_cycles !== 32'd7) $display("FAIL stats_count got %0d want 7", shift_cycles);
    else n_pass++;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_directed;
    test_random;
    test_back_to_back;
    test_rst_mid;
`ifdef SHIFT32_SEQ_STATS_EN
    test_stats;
`endif
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
